// File: rtl/bt_input_ctrl.sv
// Player-input conditioning for the burger_time core: synchronise, merge and debounce
// both joystick words, shape coin pulses, and own the pause toggle and screen-dim timer.
module bt_input_ctrl #(
    parameter int unsigned DB_TICK    = 12000,
    parameter int unsigned DB_SAMPLES = 3,
    parameter int unsigned COIN_PULSE = 1200000,
    parameter int unsigned COIN_GAP   = 600000,
    parameter int unsigned DIM_CYC    = 120000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        osd_open,
    input  logic        osd_pause_en,
    input  logic        hs_access,
    output logic        right,
    output logic        left,
    output logic        down,
    output logic        up,
    output logic        fire,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin2,
    output logic        pause,
    output logic        dim_video
);

    localparam int unsigned NB = 10;
    localparam int unsigned TW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
    localparam int unsigned CW = 21;
    localparam int unsigned DW = 27;

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_st_e;

    logic [8:0]                     sync0_a_q, sync0_a_d, sync0_b_q, sync0_b_d;
    logic [8:0]                     sync1_a_q, sync1_a_d, sync1_b_q, sync1_b_d;
    logic [NB-1:0]                  raw_c;
    logic [TW-1:0]                  pre_q, pre_d;
    logic                           tick_q, tick_d;
    logic [NB-1:0][DB_SAMPLES-1:0]  hist_q, hist_d;
    logic [NB-1:0]                  db_q, db_d;
    logic [2:0]                     prev_q, prev_d, arm_q, arm_d, rise_c;
    coin_st_e                       st_q [2];
    coin_st_e                       st_d [2];
    logic [CW-1:0]                  cnt_q [2];
    logic [CW-1:0]                  cnt_d [2];
    logic                           tog_q, tog_d;
    logic [DW-1:0]                  dim_cnt_q, dim_cnt_d;
    logic [6:0]                     btn_q, btn_d;
    logic [1:0]                     coin_q, coin_d;
    logic                           pause_q, pause_d, dim_q, dim_d;
    logic                           unused_c;

    assign unused_c = ^{joystick_0[15:9], joystick_1[15:9]};

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync0_a_q <= '0; sync0_b_q <= '0; sync1_a_q <= '0; sync1_b_q <= '0;
            pre_q     <= '0; tick_q    <= 1'b0;
            hist_q    <= '0; db_q      <= '0;
            prev_q    <= '0; arm_q     <= '0;
            st_q      <= '{C_IDLE, C_IDLE};
            cnt_q     <= '{CW'(0), CW'(0)};
            tog_q     <= 1'b0; dim_cnt_q <= '0;
            btn_q     <= '0; coin_q <= '0; pause_q <= 1'b0; dim_q <= 1'b0;
        end else begin
            sync0_a_q <= sync0_a_d; sync0_b_q <= sync0_b_d;
            sync1_a_q <= sync1_a_d; sync1_b_q <= sync1_b_d;
            pre_q     <= pre_d;     tick_q    <= tick_d;
            hist_q    <= hist_d;    db_q      <= db_d;
            prev_q    <= prev_d;    arm_q     <= arm_d;
            st_q      <= st_d;      cnt_q     <= cnt_d;
            tog_q     <= tog_d;     dim_cnt_q <= dim_cnt_d;
            btn_q     <= btn_d;     coin_q    <= coin_d;
            pause_q   <= pause_d;   dim_q     <= dim_d;
        end
    end

    // Next-state: sync, prescale, debounce, edge detect, coin FSMs, toggle and dim timer
    always_comb begin
        sync0_a_d = joystick_0[8:0];
        sync0_b_d = sync0_a_q;
        sync1_a_d = joystick_1[8:0];
        sync1_b_d = sync1_a_q;
        raw_c = {sync1_b_q[7], sync0_b_q[7], sync0_b_q[8] | sync1_b_q[8],
                 sync0_b_q[6:0] | sync1_b_q[6:0]};

        tick_d = (pre_q == TW'(DB_TICK - 1));
        pre_d  = tick_d ? '0 : pre_q + TW'(1);

        hist_d = hist_q;
        db_d   = db_q;
        for (int i = 0; i < int'(NB); i++) begin
            if (tick_q) begin
                hist_d[i] = {hist_q[i][DB_SAMPLES-2:0], raw_c[i]};
                if (&hist_d[i])  db_d[i] = 1'b1;
                if (~|hist_d[i]) db_d[i] = 1'b0;
            end
        end

        // Edges only count once the raw bit was seen low, so a bit held through reset is ignored
        prev_d = db_q[9:7];
        arm_d  = arm_q | ({3{tick_q}} & ~raw_c[9:7]);
        rise_c = db_q[9:7] & ~prev_q & arm_q;

        for (int j = 0; j < 2; j++) begin
            st_d[j]  = st_q[j];
            cnt_d[j] = cnt_q[j];
            case (st_q[j])
                C_IDLE: if (rise_c[j+1]) begin
                    st_d[j]  = C_PULSE;
                    cnt_d[j] = '0;
                end
                C_PULSE: if (cnt_q[j] == CW'(COIN_PULSE - 1)) begin
                    st_d[j]  = C_GAP;
                    cnt_d[j] = '0;
                end else begin
                    cnt_d[j] = cnt_q[j] + CW'(1);
                end
                C_GAP: if (cnt_q[j] != CW'(COIN_GAP - 1)) begin
                    cnt_d[j] = cnt_q[j] + CW'(1);
                end else if (!db_q[8+j]) begin
                    st_d[j] = C_IDLE;
                end
                default: st_d[j] = C_IDLE;
            endcase
        end

        tog_d = tog_q ^ rise_c[0];
        if (!tog_q)                            dim_cnt_d = '0;
        else if (dim_cnt_q == DW'(DIM_CYC))    dim_cnt_d = dim_cnt_q;
        else                                   dim_cnt_d = dim_cnt_q + DW'(1);
    end

    // Output logic (registered in the state register block)
    always_comb begin
        btn_d     = db_q[6:0];
        coin_d[0] = (st_d[0] == C_PULSE);
        coin_d[1] = (st_d[1] == C_PULSE);
        pause_d   = hs_access | tog_q | (osd_open & osd_pause_en);
        dim_d     = tog_q & (dim_cnt_q == DW'(DIM_CYC));
    end

    assign {start2, start1, fire, up, down, left, right} = btn_q;
    assign coin1     = coin_q[0];
    assign coin2     = coin_q[1];
    assign pause     = pause_q;
    assign dim_video = dim_q;

endmodule

// File: tb/tb_bt_input_ctrl.sv
// Directed self-checking bench for bt_input_ctrl with short debounce, coin and dim timings.
module tb_bt_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] joystick_0, joystick_1;
    logic        osd_open, osd_pause_en, hs_access;
    logic        right, left, down, up, fire, start1, start2, coin1, coin2, pause, dim_video;

    int passed = 0;
    int total  = 0;
    int c1_hi = 0, c1_rise = 0, c2_hi = 0, c2_rise = 0;
    logic c1_prev = 1'b0, c2_prev = 1'b0;

    bt_input_ctrl #(
        .DB_TICK(4), .DB_SAMPLES(3), .COIN_PULSE(10), .COIN_GAP(64), .DIM_CYC(50)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .osd_open(osd_open), .osd_pause_en(osd_pause_en), .hs_access(hs_access),
        .right(right), .left(left), .down(down), .up(up), .fire(fire),
        .start1(start1), .start2(start2), .coin1(coin1), .coin2(coin2),
        .pause(pause), .dim_video(dim_video)
    );

    always #5 clk_sys = ~clk_sys;

    // Coin pulse-width and pulse-count monitor
    always @(negedge clk_sys) begin
        c1_hi   <= c1_hi + int'(coin1);
        c2_hi   <= c2_hi + int'(coin2);
        c1_rise <= c1_rise + int'(coin1 & ~c1_prev);
        c2_rise <= c2_rise + int'(coin2 & ~c2_prev);
        c1_prev <= coin1;
        c2_prev <= coin2;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int n, m, seen, s_hi, s_rise, s2_hi, s2_rise;

        reset = 1'b1; joystick_0 = '0; joystick_1 = '0;
        osd_open = 1'b0; osd_pause_en = 1'b0; hs_access = 1'b0;
        joystick_0[8] = 1'b1;
        step(3);
        chk("reset_outputs", int'({right, left, down, up, fire, start1, start2,
                                    coin1, coin2, pause, dim_video}), 0);
        reset = 1'b0;
        step(60);
        chk("pause_held_through_reset", int'(pause), 0);
        joystick_0[8] = 1'b0;
        step(30);
        chk("pause_after_release", int'(pause), 0);

        // Test 1: 8-cycle glitch on up is rejected, stable press passes
        joystick_0[3] = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin step(1); seen |= int'(up); end
        joystick_0[3] = 1'b0;
        for (int i = 0; i < 24; i++) begin step(1); seen |= int'(up); end
        chk("up_glitch", seen, 0);
        joystick_0[3] = 1'b1;
        n = 0;
        while (!up && n < 40) begin step(1); n++; end
        chk("up_latency_in_range", int'(n >= 12 && n <= 19), 1);
        chk("up_high", int'(up), 1);
        joystick_0[3] = 1'b0;
        step(30);
        chk("up_released", int'(up), 0);

        joystick_1[0] = 1'b1;
        step(30);
        chk("right_from_p2", int'(right), 1);
        chk("left_idle", int'(left), 0);
        joystick_1[0] = 1'b0;
        step(30);

        // Test 2: held coin2 gives one 10-cycle pulse
        s_hi = c1_hi; s2_hi = c2_hi; s2_rise = c2_rise;
        joystick_1[7] = 1'b1;
        step(200);
        chk("coin2_pulses", c2_rise - s2_rise, 1);
        chk("coin2_width", c2_hi - s2_hi, 10);
        chk("coin1_quiet", c1_hi - s_hi, 0);
        joystick_1[7] = 1'b0;
        step(40);

        // Test 3: re-press during GAP ignored, press after IDLE accepted
        s_hi = c1_hi; s_rise = c1_rise;
        joystick_0[7] = 1'b1; step(30);
        joystick_0[7] = 1'b0; step(30);
        joystick_0[7] = 1'b1; step(30);
        joystick_0[7] = 1'b0; step(100);
        chk("coin1_gap_pulses", c1_rise - s_rise, 1);
        chk("coin1_gap_width", c1_hi - s_hi, 10);
        s_hi = c1_hi; s_rise = c1_rise;
        joystick_0[7] = 1'b1; step(30);
        joystick_0[7] = 1'b0; step(100);
        chk("coin1_third_pulses", c1_rise - s_rise, 1);
        chk("coin1_third_width", c1_hi - s_hi, 10);

        // Both coins in the same tick pulse together
        joystick_0[7] = 1'b1; joystick_1[7] = 1'b1;
        n = 0;
        while (!coin1 && n < 40) begin step(1); n++; end
        chk("coin1_both_seen", int'(coin1), 1);
        chk("coin2_both_same_cycle", int'(coin2), 1);
        joystick_0[7] = 1'b0; joystick_1[7] = 1'b0;
        step(100);

        // Test 4: pause toggle and dim timer
        joystick_0[8] = 1'b1;
        n = 0;
        while (!pause && n < 40) begin step(1); n++; end
        chk("pause_on", int'(pause), 1);
        joystick_0[8] = 1'b0;
        m = 0;
        while (!dim_video && m < 80) begin step(1); m++; end
        chk("dim_delay_in_range", int'(m >= 50 && m <= 51), 1);
        chk("pause_still_on", int'(pause), 1);
        step(10);
        joystick_0[8] = 1'b1;
        n = 0;
        while (pause && n < 60) begin step(1); n++; end
        chk("pause_off", int'(pause), 0);
        chk("dim_off_with_pause", int'(dim_video), 0);
        joystick_0[8] = 1'b0;
        step(30);
        chk("pause_stays_off", int'(pause), 0);

        // Test 5: OSD and hiscore pause sources never dim
        osd_open = 1'b1; osd_pause_en = 1'b0; step(2);
        chk("osd_no_pause_en", int'(pause), 0);
        osd_pause_en = 1'b1; step(2);
        chk("osd_pause_en", int'(pause), 1);
        step(60);
        chk("osd_no_dim", int'(dim_video), 0);
        osd_open = 1'b0; osd_pause_en = 1'b0; step(2);
        chk("osd_closed", int'(pause), 0);
        hs_access = 1'b1; step(2);
        chk("hs_pause", int'(pause), 1);
        step(100);
        chk("hs_no_dim", int'(dim_video), 0);
        hs_access = 1'b0; step(2);
        chk("hs_released", int'(pause), 0);

        // Test 6: reset mid-pulse with toggle set
        joystick_0[8] = 1'b1;
        n = 0;
        while (!pause && n < 40) begin step(1); n++; end
        chk("pause_on_again", int'(pause), 1);
        joystick_0[8] = 1'b0;
        step(20);
        joystick_0[7] = 1'b1;
        n = 0;
        while (!coin1 && n < 40) begin step(1); n++; end
        chk("coin1_before_reset", int'(coin1), 1);
        step(3);
        joystick_0[7] = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_async_drop", int'({coin1, pause, dim_video}), 0);
        step(3);
        reset = 1'b0;
        s_rise = c1_rise;
        step(100);
        chk("no_pulse_after_reset", c1_rise - s_rise, 0);
        chk("pause_cleared_by_reset", int'(pause), 0);
        joystick_0[7] = 1'b1;
        n = 0;
        while (!coin1 && n < 40) begin step(1); n++; end
        chk("coin1_new_edge", int'(coin1), 1);
        joystick_0[7] = 1'b0;
        step(50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
